// File: rtl/rv32_fetch_pkg.sv
// Shared types and helpers for the RV32 instruction fetch slice.
package rv32_fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StHalt
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Word-aligned and fully inside the instruction memory.
    function automatic logic addr_ok(input logic [XLEN-1:0] addr, input int unsigned mem_bytes);
        return (addr[1:0] == 2'b00) && (addr <= mem_bytes - INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer; flush beats push, push+pop on a full buffer is allowed.
module fetch_fifo
    import rv32_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  fetch_entry_t                 i_din,
    output fetch_entry_t                 o_dout,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_entry_t    r_mem [DEPTH];
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] r_wr_ptr;
    logic [CntW-1:0] r_count;
    logic            w_pop;
    logic            w_push;

    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && ((r_count != CntW'(DEPTH)) || w_pop);
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// RV32 instruction fetch controller: PC sequencing, redirect flush, sticky fetch fault.
module instr_fetch_ctrl
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 32,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_mem_addr,
    input  logic [31:0] i_mem_rd,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst_data,
    output logic [31:0] o_inst_pc,
    output logic        o_fault_valid,
    output logic [31:0] o_fault_addr,
    output logic [31:0] o_fetch_count
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_state_e    r_state;
    logic [31:0]     r_pc;
    logic            r_fault_valid;
    logic [31:0]     r_fault_addr;
    logic [31:0]     r_fetch_count;

    logic [CntW-1:0] w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_din;
    logic            w_pop;
    logic            w_space;
    logic            w_pc_ok;
    logic            w_fetch;
    logic            w_flush;

    assign w_pop   = (w_count != '0) && i_inst_ready;
    assign w_space = (w_count < CntW'(DEPTH)) || w_pop;
    assign w_pc_ok = addr_ok(r_pc, MEM_BYTES);
    assign w_flush = (r_state == StRun) && i_redirect_valid;
    assign w_fetch = (r_state == StRun) && !i_redirect_valid && w_space && w_pc_ok;
    assign w_din   = '{pc: r_pc, instr: i_mem_rd};

    assign o_mem_addr    = r_pc;
    assign o_inst_valid  = (w_count != '0);
    assign o_inst_data   = w_head.instr;
    assign o_inst_pc     = w_head.pc;
    assign o_fault_valid = r_fault_valid;
    assign o_fault_addr  = r_fault_addr;
    assign o_fetch_count = r_fetch_count;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_push (w_fetch),
        .i_pop  (w_pop),
        .i_flush(w_flush),
        .i_din  (w_din),
        .o_dout (w_head),
        .o_count(w_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StInit;
            r_pc          <= RESET_PC;
            r_fault_valid <= 1'b0;
            r_fault_addr  <= '0;
            r_fetch_count <= '0;
        end else begin
            case (r_state)
                StInit: r_state <= StRun;
                StRun: begin
                    if (i_redirect_valid) begin
                        if (addr_ok(i_redirect_pc, MEM_BYTES)) begin
                            r_pc <= i_redirect_pc;
                        end else begin
                            r_fault_valid <= 1'b1;
                            r_fault_addr  <= i_redirect_pc;
                            r_state       <= StHalt;
                        end
                    end else if (w_space) begin
                        // Out-of-range PC with room to fetch halts instead of wrapping.
                        if (w_pc_ok) begin
                            r_pc          <= r_pc + INSTR_BYTES;
                            r_fetch_count <= r_fetch_count + 32'd1;
                        end else begin
                            r_fault_valid <= 1'b1;
                            r_fault_addr  <= r_pc;
                            r_state       <= StHalt;
                        end
                    end
                end
                StHalt:  r_state <= StHalt;
                default: r_state <= StHalt;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed plus randomized bench for instr_fetch_ctrl against a queue-based fetch model.
module tb_instr_fetch_ctrl;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned MEM_BYTES = 32;
    localparam int unsigned DEPTH     = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fault_valid;
    logic [31:0] fault_addr;
    logic [31:0] fetch_count;

    logic [31:0] mem [8];
    logic [31:0] plan_words [8];

    // Reference model state
    ent_t        q[$];
    logic [31:0] m_pc;
    int          m_state;
    logic        m_fault;
    logic [31:0] m_faddr;
    logic [31:0] m_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rd = (mem_addr < MEM_BYTES) ? mem[mem_addr[4:2]] : 32'h0;

    instr_fetch_ctrl #(
        .RESET_PC (RESET_PC),
        .MEM_BYTES(MEM_BYTES),
        .DEPTH    (DEPTH)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .o_mem_addr      (mem_addr),
        .i_mem_rd        (mem_rd),
        .i_redirect_valid(redirect_valid),
        .i_redirect_pc   (redirect_pc),
        .o_inst_valid    (inst_valid),
        .i_inst_ready    (inst_ready),
        .o_inst_data     (inst_data),
        .o_inst_pc       (inst_pc),
        .o_fault_valid   (fault_valid),
        .o_fault_addr    (fault_addr),
        .o_fetch_count   (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a <= MEM_BYTES - 4);
    endfunction

    task automatic model_update(input logic rst, input logic rdy, input logic rv,
                                input logic [31:0] rpc);
        bit   pop;
        bit   space;
        ent_t e;
        if (rst) begin
            q.delete();
            m_pc    = RESET_PC;
            m_state = 0;
            m_fault = 1'b0;
            m_faddr = 32'h0;
            m_cnt   = 32'h0;
        end else begin
            pop   = (q.size() != 0) && rdy;
            space = (q.size() < DEPTH) || pop;
            if (pop) void'(q.pop_front());
            if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 1) begin
                if (rv) begin
                    q.delete();
                    if (legal(rpc)) m_pc = rpc;
                    else begin
                        m_fault = 1'b1;
                        m_faddr = rpc;
                        m_state = 2;
                    end
                end else if (space) begin
                    if (legal(m_pc)) begin
                        e.pc    = m_pc;
                        e.instr = mem[m_pc / 4];
                        q.push_back(e);
                        m_pc  = m_pc + 4;
                        m_cnt = m_cnt + 1;
                    end else begin
                        m_fault = 1'b1;
                        m_faddr = m_pc;
                        m_state = 2;
                    end
                end
            end
        end
    endtask

    task automatic compare_model();
        chk("m_valid", 32'(inst_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("m_inst_pc", inst_pc, q[0].pc);
            chk("m_inst_data", inst_data, q[0].instr);
        end
        chk("m_mem_addr", mem_addr, m_pc);
        chk("m_fault_valid", 32'(fault_valid), 32'(m_fault));
        chk("m_fault_addr", fault_addr, m_faddr);
        chk("m_fetch_count", fetch_count, m_cnt);
    endtask

    // Drive inputs, advance one clock, update the model, then sample 1ns after the edge.
    task automatic step(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
        reset          = rst;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        model_update(rst, rdy, rv, rpc);
        #1;
        compare_model();
    endtask

    initial begin
        logic rst;
        logic rdy;
        logic rv;
        logic [31:0] rpc;

        plan_words[0] = 32'hFFC4A303;
        plan_words[1] = 32'h0064A423;
        plan_words[2] = 32'h0062E233;
        plan_words[3] = 32'hFE420AE3;
        plan_words[4] = 32'h02728863;
        plan_words[5] = 32'h0;
        plan_words[6] = 32'h0;
        plan_words[7] = 32'h0;
        for (int i = 0; i < 8; i++) mem[i] = plan_words[i];
        reset = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

        // Reset values and full stream to the overrun fault
        step(1, 1, 0, 0);
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_data", inst_data, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_count", fetch_count, 0);
        chk("rst_fault", 32'(fault_valid), 0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        step(0, 1, 0, 0);
        chk("init_no_valid", 32'(inst_valid), 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", 32'(inst_valid), 1);
            chk("stream_pc", inst_pc, 32'(i * 4));
            chk("stream_data", inst_data, plan_words[i]);
            step(0, 1, 0, 0);
        end
        chk("overrun_fault", 32'(fault_valid), 1);
        chk("overrun_addr", fault_addr, 32'h20);
        chk("overrun_count", fetch_count, 8);
        chk("overrun_valid", 32'(inst_valid), 0);

        // Backpressure
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("bp_first_valid", 32'(inst_valid), 1);
        repeat (5) step(0, 0, 0, 0);
        chk("bp_head_pc", inst_pc, 0);
        chk("bp_head_data", inst_data, 32'hFFC4A303);
        chk("bp_mem_addr", mem_addr, 8);
        chk("bp_count", fetch_count, 2);
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0, 0);
            chk("bp_resume_pc", inst_pc, 32'(i * 4));
            chk("bp_resume_data", inst_data, plan_words[i]);
        end

        // Good redirect while popping pc 8, then bad redirect and HALT
        step(1, 1, 0, 0);
        repeat (4) step(0, 1, 0, 0);
        chk("rd_head8", inst_pc, 8);
        step(0, 1, 1, 32'h4);
        chk("rd_flush_valid", 32'(inst_valid), 0);
        step(0, 1, 0, 0);
        chk("rd_target_valid", 32'(inst_valid), 1);
        chk("rd_target_pc", inst_pc, 4);
        chk("rd_target_data", inst_data, 32'h0064A423);
        step(0, 1, 1, 32'h6);
        chk("bad_fault", 32'(fault_valid), 1);
        chk("bad_addr", fault_addr, 6);
        chk("bad_valid", 32'(inst_valid), 0);
        step(0, 1, 1, 32'h0);
        chk("halt_ignore_addr", mem_addr, 8);
        repeat (3) step(0, 1, 0, 0);
        chk("halt_valid", 32'(inst_valid), 0);
        chk("halt_fault_addr", fault_addr, 6);

        // Reset with a full buffer
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        chk("full_count", fetch_count, 2);
        step(1, 0, 0, 0);
        chk("mid_rst_valid", 32'(inst_valid), 0);
        chk("mid_rst_count", fetch_count, 0);
        chk("mid_rst_addr", mem_addr, RESET_PC);
        chk("mid_rst_fault", 32'(fault_valid), 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("restart_pc", inst_pc, 0);
        chk("restart_data", inst_data, 32'hFFC4A303);

        // Randomized traffic
        for (int i = 5; i < 8; i++) mem[i] = $urandom;
        step(1, 1, 0, 0);
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) < 2) || (m_state == 2 && $urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) rpc = 32'($urandom_range(0, 40));
            else rpc = 32'(4 * $urandom_range(0, 7));
            step(rst, rdy, rv, rpc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
